// File: rtl/cs_pkg.sv
// cs_pkg: shared symbol width, encoder rotation constants and erasure mask encoding
// for the 2+1 cyclic-shift erasure code.
package cs_pkg;
    localparam int CS_WIDTH    = 4;
    localparam int ENC_SHIFT_0 = 1;
    localparam int ENC_SHIFT_1 = 2;
    typedef enum logic [2:0] {
        ER_NONE   = 3'b000,
        ER_DATA_0 = 3'b001,
        ER_DATA_1 = 3'b010,
        ER_PARITY = 3'b100
    } erasure_e;
    function automatic logic multi_erasure(input logic [2:0] m);
        return (m[0] & m[1]) | (m[0] & m[2]) | (m[1] & m[2]);
    endfunction
endpackage

// File: rtl/cs_decoder_2_3_cnt.sv
// cs_decoder_2_3_cnt: saturating event counter with synchronous clear taking priority.
module cs_decoder_2_3_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (inc && cnt != '1)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/cyclic_shift.sv
// cyclic_shift: rotate a WIDTH-bit symbol left by SHIFT_AMT positions.
module cyclic_shift #(
    parameter int WIDTH     = 4,
    parameter int SHIFT_AMT = 1
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    localparam int K = SHIFT_AMT % WIDTH;
    if (K == 0) begin : g_id
        assign dout = din;
    end else begin : g_rot
        assign dout = {din[WIDTH-1-K:0], din[WIDTH-1:WIDTH-K]};
    end
endmodule

// File: rtl/cs_decoder_2_3.sv
// cs_decoder_2_3: single-erasure decoder for two data symbols plus one rotated-XOR
// parity, with a one-entry valid/ready output register and saturating statistics.
module cs_decoder_2_3
    import cs_pkg::*;
#(
    parameter int WIDTH = CS_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] coded_0,
    input  logic [WIDTH-1:0] coded_1,
    input  logic [WIDTH-1:0] coded_2,
    input  logic [2:0]       erasure,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_0,
    output logic [WIDTH-1:0] data_1,
    output logic             out_fail,
    output logic             out_recovered,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] cnt_recovered,
    output logic [CNT_W-1:0] cnt_fail
);
    logic [WIDTH-1:0] rot_c0, rot_c1, rec_0, rec_1, d0, d1;
    logic             fail, rec, in_fire, out_fire;

    assign in_ready = !out_valid || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Strip the surviving data symbol's contribution from parity, then undo its rotation.
    cyclic_shift #(.WIDTH(WIDTH), .SHIFT_AMT(ENC_SHIFT_0)) u_rot_c0 (
        .din(coded_0), .dout(rot_c0));
    cyclic_shift #(.WIDTH(WIDTH), .SHIFT_AMT(ENC_SHIFT_1)) u_rot_c1 (
        .din(coded_1), .dout(rot_c1));
    cyclic_shift #(.WIDTH(WIDTH), .SHIFT_AMT(WIDTH - ENC_SHIFT_0)) u_rec_0 (
        .din(coded_2 ^ rot_c1), .dout(rec_0));
    cyclic_shift #(.WIDTH(WIDTH), .SHIFT_AMT(WIDTH - ENC_SHIFT_1)) u_rec_1 (
        .din(coded_2 ^ rot_c0), .dout(rec_1));

    always_comb begin
        fail = multi_erasure(erasure);
        rec  = (erasure == ER_DATA_0) || (erasure == ER_DATA_1);
        d0   = fail ? '0 : (erasure == ER_DATA_0) ? rec_0 : coded_0;
        d1   = fail ? '0 : (erasure == ER_DATA_1) ? rec_1 : coded_1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            data_0        <= '0;
            data_1        <= '0;
            out_fail      <= 1'b0;
            out_recovered <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_fire) begin
                data_0        <= d0;
                data_1        <= d1;
                out_fail      <= fail;
                out_recovered <= rec;
            end
        end
    end

    cs_decoder_2_3_cnt #(.CNT_W(CNT_W)) u_cnt_rec (
        .clk(clk), .rst_n(rst_n), .clear(cnt_clear),
        .inc(out_fire && out_recovered), .cnt(cnt_recovered));
    cs_decoder_2_3_cnt #(.CNT_W(CNT_W)) u_cnt_fail (
        .clk(clk), .rst_n(rst_n), .clear(cnt_clear),
        .inc(out_fire && out_fail), .cnt(cnt_fail));
endmodule

// File: tb/tb_cs_decoder_2_3.sv
// tb_cs_decoder_2_3: table vectors, handshake corner sequences and randomized
// encode/erase/decode traffic against a data-level reference model.
module tb_cs_decoder_2_3;
    localparam int W  = 4;
    localparam int CW = 4;

    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b0, cnt_clear = 1'b0;
    logic [W-1:0] coded_0 = '0, coded_1 = '0, coded_2 = '0;
    logic [2:0] erasure = '0;
    logic in_ready, out_valid, out_fail, out_recovered;
    logic [W-1:0] data_0, data_1;
    logic [CW-1:0] cnt_recovered, cnt_fail;

    int checks = 0, errors = 0;
    int m_rec = 0, m_fail = 0;

    typedef struct packed {
        logic [2:0]   mask;
        logic [W-1:0] c0, c1, c2;
        logic [W-1:0] e0, e1;
        logic         ef, er;
    } vec_t;

    cs_decoder_2_3 #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .coded_0(coded_0), .coded_1(coded_1), .coded_2(coded_2), .erasure(erasure),
        .out_valid(out_valid), .out_ready(out_ready), .data_0(data_0), .data_1(data_1),
        .out_fail(out_fail), .out_recovered(out_recovered), .cnt_clear(cnt_clear),
        .cnt_recovered(cnt_recovered), .cnt_fail(cnt_fail));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rot(input logic [W-1:0] x, input int k);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[(i + k) % W] = x[i];
        return r;
    endfunction

    function automatic logic [31:0] result();
        return {22'd0, data_0, data_1, out_fail, out_recovered};
    endfunction

    function automatic logic [31:0] expect_of(input vec_t v);
        return {22'd0, v.e0, v.e1, v.ef, v.er};
    endfunction

    function automatic int sat_inc(input int c);
        return (c < (1 << CW) - 1) ? c + 1 : c;
    endfunction

    task automatic drive(input vec_t v);
        coded_0 = v.c0; coded_1 = v.c1; coded_2 = v.c2; erasure = v.mask;
        in_valid = 1'b1;
    endtask

    task automatic model_xfer(input vec_t v);
        if (v.er) m_rec = sat_inc(m_rec);
        if (v.ef) m_fail = sat_inc(m_fail);
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_cnt_rec"}, 32'(cnt_recovered), 32'(m_rec));
        chk({tag, "_cnt_fail"}, 32'(cnt_fail), 32'(m_fail));
    endtask

    task automatic send(input vec_t v, input int stall);
        @(negedge clk);
        drive(v);
        out_ready = 1'b0;
        #1 chk("in_ready_idle", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < stall; i++) begin
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_result", result(), expect_of(v));
            chk("stall_in_ready", 32'(in_ready), 0);
            chk_cnt("stall");
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("out_valid", 32'(out_valid), 1);
        chk("result", result(), expect_of(v));
        chk("in_ready_ack", 32'(in_ready), 1);
        @(negedge clk);
        model_xfer(v);
        chk("valid_clr", 32'(out_valid), 0);
        chk_cnt("xfer");
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        logic [W-1:0] d0, d1;
        d0 = W'($urandom); d1 = W'($urandom);
        v.mask = 3'($urandom_range(0, 7));
        v.c0 = v.mask[0] ? W'($urandom) : d0;
        v.c1 = v.mask[1] ? W'($urandom) : d1;
        v.c2 = v.mask[2] ? W'($urandom) : (rot(d0, 1) ^ rot(d1, 2));
        v.ef = $countones(v.mask) >= 2;
        v.er = !v.ef && (v.mask[0] || v.mask[1]);
        v.e0 = v.ef ? '0 : d0;
        v.e1 = v.ef ? '0 : d1;
        return v;
    endfunction

    vec_t tbl[8];
    vec_t va, vb, vf;

    initial begin
        tbl[0] = '{3'b000, 4'b0101, 4'b0011, 4'b0110, 4'b0101, 4'b0011, 1'b0, 1'b0};
        tbl[1] = '{3'b001, 4'b1010, 4'b0011, 4'b0110, 4'b0101, 4'b0011, 1'b0, 1'b1};
        tbl[2] = '{3'b010, 4'b1111, 4'b0000, 4'b0110, 4'b1111, 4'b0110, 1'b0, 1'b1};
        tbl[3] = '{3'b011, 4'b0101, 4'b0011, 4'b0110, 4'b0000, 4'b0000, 1'b1, 1'b0};
        tbl[4] = '{3'b100, 4'b0101, 4'b0011, 4'b1111, 4'b0101, 4'b0011, 1'b0, 1'b0};
        tbl[5] = '{3'b111, 4'b1001, 4'b0110, 4'b1100, 4'b0000, 4'b0000, 1'b1, 1'b0};
        tbl[6] = '{3'b110, 4'b1001, 4'b0110, 4'b1100, 4'b0000, 4'b0000, 1'b1, 1'b0};
        tbl[7] = '{3'b101, 4'b1001, 4'b0110, 4'b1100, 4'b0000, 4'b0000, 1'b1, 1'b0};

        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_result", result(), 0);
        chk_cnt("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rst_in_ready", 32'(in_ready), 1);

        foreach (tbl[i]) send(tbl[i], i % 3);

        // Stall three cycles, then accept the stalled result and a new input together.
        va = tbl[1]; vb = tbl[2];
        @(negedge clk);
        drive(va); out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) begin
            chk("b2b_stall_in_ready", 32'(in_ready), 0);
            chk("b2b_stall_result", result(), expect_of(va));
            chk_cnt("b2b_stall");
            @(negedge clk);
        end
        drive(vb); out_ready = 1'b1;
        #1 chk("b2b_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        model_xfer(va);
        chk("b2b_valid", 32'(out_valid), 1);
        chk("b2b_result", result(), expect_of(vb));
        chk_cnt("b2b_first");
        @(negedge clk);
        model_xfer(vb);
        chk("b2b_drain", 32'(out_valid), 0);
        chk_cnt("b2b_second");

        vf = tbl[3];
        for (int i = 0; i < 17; i++) send(vf, 0);
        chk("fail_saturated", 32'(cnt_fail), 15);

        // Clear lands on the same edge as a failure transfer.
        @(negedge clk);
        drive(vf); out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; cnt_clear = 1'b1;
        chk("clr_valid", 32'(out_valid), 1);
        @(negedge clk);
        cnt_clear = 1'b0;
        m_rec = 0; m_fail = 0;
        chk_cnt("clear");

        for (int i = 0; i < 150; i++) send(rand_vec(), int'($urandom_range(0, 2)));

        // Asynchronous reset while a result is stalled.
        @(negedge clk);
        drive(tbl[1]); out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        m_rec = 0; m_fail = 0;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_result", result(), 0);
        chk("arst_in_ready", 32'(in_ready), 1);
        chk_cnt("arst");
        @(negedge clk);
        rst_n = 1'b1;
        send(tbl[2], 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/cs_decoder_2_3.md
CS_DECODER_2_3 -- requirements
Module: cs_decoder_2_3

Interface
REQ-001 Parameter: WIDTH, default 4, symbol width in bits (L-1).
REQ-002 Parameter: CNT_W, default 16, width of the statistics counters.
REQ-003 clk  input  1  clock; all state on the rising edge.
REQ-004 rst_n  input  1  reset: asynchronous, active-low.
REQ-005 in_valid  input  1  coded triple and erasure mask are valid.
REQ-006 in_ready  output  1  decoder accepts the input this cycle.
REQ-007 coded_0, coded_1  input  WIDTH each  systematic symbols (data_0, data_1).
REQ-008 coded_2  input  WIDTH  parity symbol = shift(data_0,1) XOR shift(data_1,2).
REQ-009 erasure  input  3  bit i set means coded_i is lost; its value is don't-care.
REQ-010 out_valid  output  1  decoded result valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 data_0, data_1  output  WIDTH each  recovered data symbols.
REQ-013 out_fail  output  1  more than one erasure; data outputs forced to zero.
REQ-014 out_recovered  output  1  a systematic symbol was rebuilt from parity.
REQ-015 cnt_clear  input  1  synchronous clear of both counters.
REQ-016 cnt_recovered, cnt_fail  output  CNT_W each  event counters.

Function
REQ-017 Input handshake: a transfer occurs when in_valid && in_ready.
REQ-018 Output handshake: a transfer occurs when out_valid && out_ready.
REQ-019 Single-entry pipeline register: in_ready = !out_valid || out_ready (combinational).
REQ-020 Latency is exactly 1 cycle from input transfer to out_valid.
REQ-021 While out_valid && !out_ready, all outputs hold stable.
REQ-022 Simultaneous output and input transfers in one cycle load the new result with no bubble.
REQ-023 With no new input transfer, an output transfer clears out_valid.
REQ-024 Mask 000 or 100: data_0 = coded_0, data_1 = coded_1, out_recovered=0, out_fail=0.
REQ-025 Mask 001: data_0 = shift(coded_2 XOR shift(coded_1,2), WIDTH-1); out_recovered=1.
REQ-026 Mask 010: data_1 = shift(coded_2 XOR shift(coded_0,1), WIDTH-2); out_recovered=1.
REQ-027 The shift operation is the same cyclic rotation used by the encoder. Rotating by k and then by WIDTH-k returns the original value, so recovery is independent of rotation direction.
REQ-028 Mask with two or more bits set: out_fail=1, data_0=data_1=0, out_recovered=0.
REQ-029 cnt_recovered increments by 1 on each output transfer with out_recovered=1.
REQ-030 cnt_fail increments by 1 on each output transfer with out_fail=1.
REQ-031 Both counters saturate at 2^CNT_W-1 and do not wrap.
REQ-032 cnt_clear has priority over a same-cycle increment; the counter reads 0 the next cycle.
REQ-033 Counters count output transfers, not input transfers; a stalled result counts once.

Reset
REQ-034 Reset applies asynchronously on the falling edge of rst_n; release is synchronous to clk.
REQ-035 Reset values: out_valid=0, data_0=data_1=0, out_fail=0, out_recovered=0, counters=0.
REQ-036 in_ready is 1 during reset and in the first cycle after release.
REQ-037 Reset during a stall discards the pending result; no counter update occurs.

Structure
REQ-038 WIDTH default, encoder shift constants (1, 2) and the erasure mask encoding live in a shared cs_pkg package, used by both encoder and decoder.
REQ-039 Recovery rotations reuse the existing cyclic_shift sub-module: four instances, with SHIFT_AMT 1, 2, WIDTH-1 and WIDTH-2.
REQ-040 Decode logic is combinational ahead of a single output register stage; no other storage except the counters.

Verification
REQ-041 Mask 000, coded 0101/0011/0110, out_ready=1 -> next cycle: data 0101/0011, fail=0, recovered=0.
REQ-042 Mask 001, coded_1=0011, coded_2=0110 -> data_0=0101, data_1=0011, recovered=1, cnt_recovered=1 after the transfer.
REQ-043 Mask 010, coded_0=1111, coded_2=0110 -> data_1=0110, data_0=1111, recovered=1.
REQ-044 Mask 011 -> out_fail=1, data 0000/0000, cnt_fail increments by 1; mask 100 decodes normally.
REQ-045 Hold out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, outputs stable, counters unchanged. Raise out_ready together with a new input -> back-to-back results with no bubble.
REQ-046 Preload cnt_fail to saturation via repeated failures (CNT_W=4: 16 failures) -> holds at 15. Assert cnt_clear together with a failure transfer -> counter reads 0.
